// File: rtl/mips_ctrl_pkg.sv
// Shared types for the multi-cycle MIPS control path: FSM states, opcode values,
// decoded opcode classes and ALU operation encodings.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [2:0] {
    CL_NONE,
    CL_RTYPE,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_J,
    CL_ADDI
  } op_class_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/mips_main_decoder.sv
// Combinational opcode-to-class decode; zero latency, no flow control.
// Unsupported opcodes map to CL_NONE with illegal raised.
module mips_main_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  op_class,
  output logic       illegal
);

  always_comb begin
    op_class = CL_NONE;
    illegal  = 1'b0;
    case (opcode)
      OP_RTYPE: op_class = CL_RTYPE;
      OP_LW:    op_class = CL_LW;
      OP_SW:    op_class = CL_SW;
      OP_BEQ:   op_class = CL_BEQ;
      OP_J:     op_class = CL_J;
      OP_ADDI:  op_class = CL_ADDI;
      default:  illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: Moore outputs from state + latched opcode class; 3-5 cycles/instr.
// Memory handshake holds mem_req until mem_ready; stall freezes state and blocks all strobes.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  input  logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             jump_en,
  output logic             branch_en,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             illegal_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count
);

  state_t    state, state_nxt;
  op_class_t cls, cls_nxt;
  op_class_t dec_class;
  logic      dec_illegal;

  // funct is consumed by the downstream ALU control when alu_op selects it.
  logic unused_funct;
  assign unused_funct = ^funct;

  mips_main_decoder u_dec (
    .opcode   (opcode),
    .op_class (dec_class),
    .illegal  (dec_illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cls         <= CL_NONE;
      instr_count <= '0;
    end else if (!stall) begin
      state <= state_nxt;
      cls   <= cls_nxt;
      if (pc_write) instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_nxt  = state;
    cls_nxt    = cls;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    jump_en    = 1'b0;
    branch_en  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    illegal_op = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready && !stall) begin
          ir_write  = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        cls_nxt = dec_class;
        if (dec_illegal) begin
          illegal_op = !stall;
          state_nxt  = S_FETCH;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          CL_RTYPE: begin
            alu_op    = ALU_FUNCT;
            state_nxt = S_WB;
          end
          CL_LW, CL_SW: begin
            alu_src   = 1'b1;
            state_nxt = S_MEM;
          end
          CL_ADDI: begin
            alu_src   = 1'b1;
            state_nxt = S_WB;
          end
          CL_BEQ: begin
            alu_op    = ALU_SUB;
            branch_en = 1'b1;
            pc_write  = !stall;
            state_nxt = S_FETCH;
          end
          CL_J: begin
            jump_en   = 1'b1;
            pc_write  = !stall;
            state_nxt = S_FETCH;
          end
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (cls == CL_SW);
        if (mem_ready && !stall) begin
          if (cls == CL_SW) begin
            pc_write  = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write  = !stall;
        reg_dst    = (cls == CL_RTYPE);
        mem_to_reg = (cls == CL_LW);
        pc_write   = !stall;
        state_nxt  = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
    instr_done = pc_write;
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed scenarios plus random opcode/mem_ready/stall traffic,
// checked every cycle against an instruction-plan model (one letter per cycle phase).
module tb_mips_multicycle_ctrl;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [5:0]       opcode = '0;
  logic [5:0]       funct = '0;
  logic             mem_ready = 1'b0;
  logic             stall = 1'b0;
  logic             mem_req, mem_we, iord, ir_write, pc_write, jump_en, branch_en;
  logic             reg_write, reg_dst, mem_to_reg, alu_src, illegal_op, instr_done;
  logic [1:0]       alu_op;
  logic [CNT_W-1:0] instr_count;
  logic [14:0]      dut_outs;

  int n_checks = 0;
  int n_errors = 0;

  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct       (funct),
    .mem_ready   (mem_ready),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .iord        (iord),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .jump_en     (jump_en),
    .branch_en   (branch_en),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .alu_src     (alu_src),
    .alu_op      (alu_op),
    .illegal_op  (illegal_op),
    .instr_done  (instr_done),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  assign dut_outs = {mem_req, mem_we, iord, ir_write, pc_write, jump_en, branch_en,
                     reg_write, reg_dst, mem_to_reg, alu_src, alu_op, illegal_op, instr_done};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: each instruction is a string of phases (F fetch, D decode, E exec, M mem, W writeback).
  bit    m_idle;
  string m_plan;
  int    m_pos;
  string m_kind;
  int    m_cnt;

  function automatic string kind_of(input logic [5:0] op);
    case (op)
      6'h00:   return "r";
      6'h23:   return "lw";
      6'h2B:   return "sw";
      6'h04:   return "beq";
      6'h02:   return "j";
      6'h08:   return "addi";
      default: return "ill";
    endcase
  endfunction

  function automatic string plan_of(input string k);
    if (k == "r" || k == "addi") return "FDEW";
    if (k == "lw")               return "FDEMW";
    if (k == "sw")               return "FDEM";
    if (k == "beq" || k == "j")  return "FDE";
    return "FD";
  endfunction

  task automatic model_reset();
    m_idle = 1'b1;
    m_plan = "FD";
    m_pos  = 0;
    m_kind = "";
    m_cnt  = 0;
  endtask

  task automatic cycle(input logic [5:0] op, input logic mr, input logic st);
    byte         c;
    string       k, pl;
    bit          adv, last, ret;
    logic [1:0]  aop;
    logic [14:0] e;
    @(negedge clk);
    opcode    = op;
    funct     = 6'($urandom);
    mem_ready = mr;
    stall     = st;
    #1;
    c    = m_idle ? "I" : m_plan[m_pos];
    k    = (c == "D") ? kind_of(op) : m_kind;
    pl   = (c == "D") ? plan_of(k) : m_plan;
    adv  = !st && !((c == "F" || c == "M") && !mr);
    last = adv && !m_idle && (m_pos == pl.len() - 1);
    ret  = last && (k != "ill");
    aop  = (c == "E" && k == "r") ? 2'b10 : (c == "E" && k == "beq") ? 2'b01 : 2'b00;
    e = {(c == "F" || c == "M"), (c == "M" && k == "sw"), (c == "M"), (c == "F" && adv),
         ret, (c == "E" && k == "j"), (c == "E" && k == "beq"),
         (c == "W" && !st), (c == "W" && k == "r"), (c == "W" && k == "lw"),
         (c == "E" && (k == "lw" || k == "sw" || k == "addi")), aop,
         (c == "D" && k == "ill" && !st), ret};
    check("outs", {17'd0, dut_outs}, {17'd0, e});
    check("count", 32'(instr_count), 32'(m_cnt));
    if (adv) begin
      if (m_idle) begin
        m_idle = 1'b0;
        m_plan = "FD";
        m_pos  = 0;
      end else if (last) begin
        m_plan = "FD";
        m_pos  = 0;
      end else begin
        if (c == "D") begin
          m_kind = k;
          m_plan = pl;
        end
        m_pos++;
      end
    end
    if (ret) m_cnt = (m_cnt + 1) % (1 << CNT_W);
  endtask

  // Reset is asserted and released between edges so the following cycle sees S_IDLE.
  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("rst_outs", {17'd0, dut_outs}, 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  logic [5:0] ops [8] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h11};

  initial begin
    model_reset();
    do_reset();

    // j with zero-wait memory: IDLE, FETCH, DECODE, EXEC
    repeat (4) cycle(6'h02, 1'b1, 1'b0);
    @(posedge clk);
    #1 check("j_count", 32'(instr_count), 32'd1);

    // lw with two wait cycles in S_MEM
    cycle(6'h23, 1'b1, 1'b0);
    cycle(6'h23, 1'b0, 1'b0);
    cycle(6'h23, 1'b0, 1'b0);
    cycle(6'h23, 1'b0, 1'b0);
    cycle(6'h23, 1'b0, 1'b0);
    cycle(6'h23, 1'b1, 1'b0);
    cycle(6'h23, 1'b1, 1'b0);

    // beq then sw back to back
    repeat (3) cycle(6'h04, 1'b1, 1'b0);
    repeat (4) cycle(6'h2B, 1'b1, 1'b0);

    // unsupported opcode
    repeat (2) cycle(6'h3F, 1'b1, 1'b0);

    // R-type stalled three cycles in S_EXEC with mem_ready high
    cycle(6'h00, 1'b1, 1'b0);
    cycle(6'h00, 1'b1, 1'b0);
    repeat (3) cycle(6'h00, 1'b1, 1'b1);
    cycle(6'h00, 1'b1, 1'b0);
    cycle(6'h00, 1'b1, 1'b0);

    // reset while lw waits in S_MEM
    cycle(6'h23, 1'b1, 1'b0);
    cycle(6'h23, 1'b1, 1'b0);
    cycle(6'h23, 1'b0, 1'b0);
    cycle(6'h23, 1'b0, 1'b0);
    do_reset();

    // five retirements wrap a 2-bit counter to 1
    repeat (16) cycle(6'h02, 1'b1, 1'b0);
    @(posedge clk);
    #1 check("wrap_count", 32'(instr_count), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      if (i % 750 == 749) do_reset();
      cycle(ops[$urandom_range(0, 7)], 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 5) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle control FSM for the MIPS core. It sequences instruction fetch, decode, execute, memory and writeback, and drives the program counter's `pc_write`/`jump_en`/`branch_en` qualifiers, plus the register-file, ALU and memory controls. It sits beside the program counter and datapath, reads the opcode/funct fields from the instruction register, and handshakes with a single shared instruction/data memory port.

## Interface
Parameters:
- `CNT_W`, 16, width of retired-instruction counter

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low; low forces FSM to S_IDLE
- `opcode`  in  6  instr[31:26] from instruction register; valid from S_DECODE onward
- `funct`  in  6  instr[5:0]; valid from S_DECODE onward
- `mem_ready`  in  1  memory completes the current request this cycle
- `stall`  in  1  freeze FSM in current state
- `mem_req`  out  1  memory request, held until `mem_ready`
- `mem_we`  out  1  write qualifier for `mem_req` (sw only)
- `iord`  out  1  0 = address from PC, 1 = address from ALU result
- `ir_write`  out  1  load instruction register
- `pc_write`  out  1  one-cycle PC update strobe, one per instruction
- `jump_en`, `branch_en`  out  1 each  PC next-address select, valid only with `pc_write`
- `reg_write`, `reg_dst`, `mem_to_reg`, `alu_src`  out  1 each  register-file/ALU mux controls
- `alu_op`  out  2  00 add, 01 sub, 10 use funct
- `illegal_op`  out  1  one-cycle pulse on unsupported opcode
- `instr_done`  out  1  one-cycle pulse when an instruction retires
- `instr_count`  out  CNT_W  retired-instruction count

## Operation
- States: S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB.
- Supported opcodes: 0x00 R-type, 0x23 lw, 0x2B sw, 0x04 beq, 0x02 j, 0x08 addi.
- S_IDLE: all outputs 0; next cycle goes to S_FETCH.
- S_FETCH: `mem_req`=1, `iord`=0, `mem_we`=0. `ir_write`=1 only in the cycle `mem_ready`=1; advances to S_DECODE on that cycle, otherwise holds.
- S_DECODE: latches opcode class.
  - Unsupported opcode: `illegal_op` pulses and the FSM goes to S_FETCH. No `pc_write`; the PC does not advance.
  - Supported opcode: goes to S_EXEC.
- S_EXEC:
  - R-type: `alu_op`=10.
  - lw/sw/addi: `alu_src`=1, `alu_op`=00.
  - beq: `alu_op`=01, `pc_write`=1, `branch_en`=1. Zero-flag qualification happens in the PC. Goes to S_FETCH (retire).
  - j: `pc_write`=1, `jump_en`=1. Goes to S_FETCH (retire).
  - lw/sw go to S_MEM; R-type/addi go to S_WB.
- S_MEM: `mem_req`=1, `iord`=1, `mem_we`=(sw). Holds until `mem_ready`.
  - lw then goes to S_WB.
  - sw retires in the `mem_ready` cycle with `pc_write`=1, then goes to S_FETCH.
- S_WB: `reg_write`=1. `reg_dst`=1 for R-type, `mem_to_reg`=1 for lw. Sets `pc_write`=1 (sequential PC+4), then goes to S_FETCH.
- Retire cycle: exactly the cycle with `pc_write`=1. `instr_done`=1 in that cycle; `instr_count` increments on that edge and wraps from 2^CNT_W−1 to 0.
- `stall`=1: state, counter and latched opcode hold.
  - `pc_write`, `ir_write`, `reg_write`, `instr_done` and `illegal_op` are forced 0.
  - `mem_req` stays asserted if already asserted, but `mem_ready` is ignored that cycle.
- `stall` and `mem_ready` in the same cycle: stall wins. Memory must re-present `mem_ready`.

## Timing
- Outputs are Moore, decoded from the state register and latched opcode class. `ir_write` and S_MEM retirement also depend on `mem_ready`.
- Reset (asynchronous, mid-operation included): state=S_IDLE, `instr_count`=0, latched opcode=0. All outputs 0 while `reset` is low and in S_IDLE. First S_FETCH is one cycle after reset release.
- Cycles per instruction with zero-wait memory (`mem_ready` high in the first request cycle): j/beq 3, sw 4, R-type/addi 4, lw 5. Each memory wait cycle adds 1.
- `pc_write` is never asserted on consecutive cycles.

## Structure
- Shared package `mips_ctrl_pkg`: state enum, opcode constants, opcode-class enum, `alu_op` encodings.
- Sub-module `mips_main_decoder`: combinational opcode to class/illegal. The FSM, counter and output decode live in the top.

## Test plan
- Reset release, `mem_ready`=1, IR=j (0x02) → IDLE, FETCH, DECODE, EXEC; `jump_en`=`pc_write`=1 in cycle 4; `instr_count`=1.
- lw with `mem_ready` delayed 2 cycles in S_MEM → 7 cycles total; `reg_write`=`mem_to_reg`=1 only in S_WB.
- beq then sw back to back → exactly two `pc_write` pulses; `branch_en` only with the first, `mem_we`=1 only in the sw S_MEM.
- Opcode 0x3F → `illegal_op` pulse, no `pc_write`, `instr_count` unchanged, FSM back in S_FETCH.
- `stall` held 3 cycles in S_EXEC of R-type, with `mem_ready` asserted during the stall → no state change, no strobes; resumes and retires in S_WB.
- `reset` pulsed low in S_MEM, and CNT_W=2 with 5 retirements → outputs 0 immediately on reset, count 0; wrap test yields `instr_count`=1.
